rv32i_wb_arbiter: RTL and testbench



---
 rtl/rv32i_wb_arbiter_if.sv | 32 +++
 rtl/rv32i_wb_arbiter.sv | 107 ++++++++++
 tb/tb_rv32i_wb_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_wb_arbiter_if.sv
// Bundle between the producers (ALU result stream, load responses) and the
// write-back arbiter, including the register-file write port it drives.
interface rv32i_wb_arbiter_if #(
  parameter int CNT_W = 2
);
  logic             I_ALU_VALID;
  logic             O_ALU_READY;
  logic [4:0]       I_ALU_RD;
  logic [31:0]      I_ALU_DATA;
  logic             I_LD_VALID;
  logic [4:0]       I_LD_RD;
  logic [31:0]      I_LD_DATA;
  logic [2:0]       I_LD_FUNCT3;
  logic [1:0]       I_LD_ADDR_LO;
  logic [4:0]       O_DST_ADDR;
  logic [31:0]      O_DST_DATA;
  logic             O_WR_EN;
  logic             O_LD_ERR;
  logic [CNT_W-1:0] O_BUF_CNT;

  modport master (
    output I_ALU_VALID, I_ALU_RD, I_ALU_DATA,
    output I_LD_VALID, I_LD_RD, I_LD_DATA, I_LD_FUNCT3, I_LD_ADDR_LO,
    input  O_ALU_READY, O_DST_ADDR, O_DST_DATA, O_WR_EN, O_LD_ERR, O_BUF_CNT
  );

  modport slave (
    input  I_ALU_VALID, I_ALU_RD, I_ALU_DATA,
    input  I_LD_VALID, I_LD_RD, I_LD_DATA, I_LD_FUNCT3, I_LD_ADDR_LO,
    output O_ALU_READY, O_DST_ADDR, O_DST_DATA, O_WR_EN, O_LD_ERR, O_BUF_CNT
  );
endinterface

// File: rtl/rv32i_wb_arbiter.sv
// RV32I write-back arbiter: merges load responses (absolute priority, extended
// here) and a FIFO-buffered ALU result stream onto one register-file write port.
module rv32i_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic               I_CLK,
  input  logic               I_RST,
  rv32i_wb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [4:0]       mem_rd_q  [DEPTH];
  logic [31:0]      mem_dat_q [DEPTH];
  logic [PTR_W-1:0] wp_q, rp_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en_q, wr_en_d, ld_err_q, ld_err_d;
  logic [4:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;

  logic        ready, alu_keep, ld_legal, ld_win, fifo_ne, deq, bypass, enq;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  assign ready    = cnt_q < CNT_W'(DEPTH);
  assign alu_keep = bus.I_ALU_VALID & ready & (bus.I_ALU_RD != 5'd0);

  assign ld_byte = bus.I_LD_DATA[{bus.I_LD_ADDR_LO, 3'b000} +: 8];
  assign ld_half = bus.I_LD_ADDR_LO[1] ? bus.I_LD_DATA[31:16] : bus.I_LD_DATA[15:0];

  always_comb begin
    ld_legal = 1'b0;
    ld_val   = '0;
    case (bus.I_LD_FUNCT3)
      3'd0: begin ld_legal = 1'b1;                      ld_val = {{24{ld_byte[7]}}, ld_byte}; end
      3'd4: begin ld_legal = 1'b1;                      ld_val = {24'd0, ld_byte}; end
      3'd1: begin ld_legal = ~bus.I_LD_ADDR_LO[0];      ld_val = {{16{ld_half[15]}}, ld_half}; end
      3'd5: begin ld_legal = ~bus.I_LD_ADDR_LO[0];      ld_val = {16'd0, ld_half}; end
      3'd2: begin ld_legal = (bus.I_LD_ADDR_LO == 2'd0); ld_val = bus.I_LD_DATA; end
      default: ;
    endcase
  end

  // A load to x0 never claims the port, so the FIFO head or bypass can use it.
  assign ld_win  = bus.I_LD_VALID & ld_legal & (bus.I_LD_RD != 5'd0);
  assign fifo_ne = (cnt_q != '0);
  assign deq     = ~ld_win & fifo_ne;
  assign bypass  = ~ld_win & ~fifo_ne & alu_keep;
  assign enq     = alu_keep & ~bypass;
  assign cnt_d   = cnt_q + CNT_W'(enq) - CNT_W'(deq);
  assign ld_err_d = bus.I_LD_VALID & ~ld_legal;

  always_comb begin
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (ld_win) begin
      wr_en_d = 1'b1;
      addr_d  = bus.I_LD_RD;
      data_d  = ld_val;
    end else if (deq) begin
      wr_en_d = 1'b1;
      addr_d  = mem_rd_q[rp_q];
      data_d  = mem_dat_q[rp_q];
    end else if (bypass) begin
      wr_en_d = 1'b1;
      addr_d  = bus.I_ALU_RD;
      data_d  = bus.I_ALU_DATA;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      ld_err_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      if (enq) wp_q <= wp_q + 1'b1;
      if (deq) rp_q <= rp_q + 1'b1;
      cnt_q    <= cnt_d;
      wr_en_q  <= wr_en_d;
      ld_err_q <= ld_err_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge I_CLK) begin
    if (!I_RST && enq) begin
      mem_rd_q[wp_q]  <= bus.I_ALU_RD;
      mem_dat_q[wp_q] <= bus.I_ALU_DATA;
    end
  end

  assign bus.O_ALU_READY = ready;
  assign bus.O_DST_ADDR  = addr_q;
  assign bus.O_DST_DATA  = data_q;
  assign bus.O_WR_EN     = wr_en_q;
  assign bus.O_LD_ERR    = ld_err_q;
  assign bus.O_BUF_CNT   = cnt_q;
endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Bench for rv32i_wb_arbiter: directed scenarios plus a randomized run against
// a queue-based reference model of the write-back rules.
module tb_rv32i_wb_arbiter;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_wb_arbiter_if #(.CNT_W(2)) bus ();
  rv32i_wb_arbiter #(.DEPTH(DEPTH), .CNT_W(2)) dut (.I_CLK(clk), .I_RST(rst), .bus(bus));

  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t q[$];
  logic        exp_wr, exp_err;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  int          exp_cnt;
  int vecs = 0;
  int miss = 0;

  function automatic void ld_ref(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w,
                                 output logic legal, output logic [31:0] val);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * (lo / 2))) & 32'hFFFF;
    legal = 1'b0; val = 32'd0;
    case (f3)
      3'd0: begin legal = 1'b1; val = (b >= 128) ? b - 32'd256 : b; end
      3'd4: begin legal = 1'b1; val = b; end
      3'd1: begin legal = (lo % 2 == 0); val = (h >= 32768) ? h - 32'd65536 : h; end
      3'd5: begin legal = (lo % 2 == 0); val = h; end
      3'd2: begin legal = (lo == 0); val = w; end
      default: ;
    endcase
  endfunction

  // Apply one cycle of inputs, advance the model, land #1 after the edge.
  task automatic cyc(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic lv, input logic [4:0] lr, input logic [31:0] lw,
                     input logic [2:0] f3, input logic [1:0] lo);
    logic legal, keep;
    logic [31:0] lval;
    ent_t e, h;
    bus.I_ALU_VALID = av; bus.I_ALU_RD = ar; bus.I_ALU_DATA = ad;
    bus.I_LD_VALID = lv; bus.I_LD_RD = lr; bus.I_LD_DATA = lw;
    bus.I_LD_FUNCT3 = f3; bus.I_LD_ADDR_LO = lo;
    ld_ref(f3, lo, lw, legal, lval);
    keep = av && (q.size() < DEPTH) && (ar != 0);
    e.rd = ar; e.d = ad;
    exp_err = lv && !legal;
    if (lv && legal && lr != 0) begin
      exp_wr = 1'b1; exp_addr = lr; exp_data = lval;
      if (keep) q.push_back(e);
    end else if (q.size() > 0) begin
      h = q.pop_front();
      exp_wr = 1'b1; exp_addr = h.rd; exp_data = h.d;
      if (keep) q.push_back(e);
    end else if (keep) begin
      exp_wr = 1'b1; exp_addr = ar; exp_data = ad;
    end else exp_wr = 1'b0;
    @(posedge clk); #1;
    exp_cnt = q.size();
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    bus.I_ALU_VALID = 1'b1; bus.I_ALU_RD = 5'd9; bus.I_ALU_DATA = 32'h5;
    bus.I_LD_VALID = 1'b1; bus.I_LD_RD = 5'd8; bus.I_LD_DATA = 32'h7;
    bus.I_LD_FUNCT3 = 3'd2; bus.I_LD_ADDR_LO = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    exp_wr = 1'b0; exp_err = 1'b0; exp_cnt = 0; exp_addr = '0; exp_data = '0;
  endtask

  task automatic test_reset();
    reset_pulse();
    vecs++; if (bus.O_WR_EN !== 1'b0) begin miss++; $display("FAIL reset_wr got %0b want 0", bus.O_WR_EN); end
    vecs++; if (bus.O_DST_ADDR !== 5'd0 || bus.O_DST_DATA !== 32'd0) begin miss++; $display("FAIL reset_addr_data got %0d/%h want 0/0", bus.O_DST_ADDR, bus.O_DST_DATA); end
    vecs++; if (bus.O_LD_ERR !== 1'b0 || bus.O_BUF_CNT !== 2'd0) begin miss++; $display("FAIL reset_err_cnt got %0b/%0d want 0/0", bus.O_LD_ERR, bus.O_BUF_CNT); end
    vecs++; if (bus.O_ALU_READY !== 1'b1) begin miss++; $display("FAIL reset_ready got %0b want 1", bus.O_ALU_READY); end
  endtask

  task automatic test_bypass();
    cyc(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    vecs++; if (bus.O_WR_EN !== 1'b1 || bus.O_DST_ADDR !== 5'd5 || bus.O_DST_DATA !== 32'h12345678)
      begin miss++; $display("FAIL bypass_write got %0b x%0d=%h want 1 x5=12345678", bus.O_WR_EN, bus.O_DST_ADDR, bus.O_DST_DATA); end
    vecs++; if (bus.O_BUF_CNT !== 2'd0) begin miss++; $display("FAIL bypass_cnt got %0d want 0", bus.O_BUF_CNT); end
    idle();
    vecs++; if (bus.O_WR_EN !== 1'b0) begin miss++; $display("FAIL bypass_single got %0b want 0", bus.O_WR_EN); end
  endtask

  task automatic test_collision();
    cyc(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd7, 32'h00800000, 3'd0, 2'd2);
    vecs++; if (bus.O_WR_EN !== 1'b1 || bus.O_DST_ADDR !== 5'd7 || bus.O_DST_DATA !== 32'hFFFFFF80 || bus.O_BUF_CNT !== 2'd1)
      begin miss++; $display("FAIL collision_load got %0b x%0d=%h cnt%0d want 1 x7=ffffff80 cnt1", bus.O_WR_EN, bus.O_DST_ADDR, bus.O_DST_DATA, bus.O_BUF_CNT); end
    idle();
    vecs++; if (bus.O_WR_EN !== 1'b1 || bus.O_DST_ADDR !== 5'd3 || bus.O_DST_DATA !== 32'hAAAA0000 || bus.O_BUF_CNT !== 2'd0)
      begin miss++; $display("FAIL collision_alu got %0b x%0d=%h cnt%0d want 1 x3=aaaa0000 cnt0", bus.O_WR_EN, bus.O_DST_ADDR, bus.O_DST_DATA, bus.O_BUF_CNT); end
  endtask

  task automatic test_backpressure();
    logic [2:0]  rdy_w [6] = '{1, 1, 0, 0, 1, 1};
    logic [4:0]  wr_rd [6] = '{10, 11, 12, 1, 2, 3};
    logic [4:0]  offer;
    for (int i = 0; i < 6; i++) begin
      vecs++; if (bus.O_ALU_READY !== rdy_w[i][0]) begin miss++; $display("FAIL bp_ready[%0d] got %0b want %0b", i, bus.O_ALU_READY, rdy_w[i][0]); end
      offer = (i < 2) ? 5'(i + 1) : 5'd3;
      if (i < 3) cyc(1'b1, offer, 32'h100 + offer, 1'b1, 5'(10 + i), 32'hC0DE0000 + i, 3'd2, 2'd0);
      else if (i < 5) cyc(1'b1, offer, 32'h100 + offer, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
      else idle();
      vecs++; if (bus.O_WR_EN !== 1'b1 || bus.O_DST_ADDR !== wr_rd[i])
        begin miss++; $display("FAIL bp_order[%0d] got %0b x%0d want 1 x%0d", i, bus.O_WR_EN, bus.O_DST_ADDR, wr_rd[i]); end
    end
    vecs++; if (bus.O_DST_DATA !== 32'h103) begin miss++; $display("FAIL bp_data got %h want 103", bus.O_DST_DATA); end
    idle();
    vecs++; if (bus.O_WR_EN !== 1'b0 || bus.O_BUF_CNT !== 2'd0) begin miss++; $display("FAIL bp_drained got %0b cnt%0d want 0 cnt0", bus.O_WR_EN, bus.O_BUF_CNT); end
  endtask

  task automatic test_extension();
    logic [2:0]  f3 [4] = '{5, 1, 2, 4};
    logic [1:0]  lo [4] = '{2, 2, 0, 3};
    logic [31:0] w  [4] = '{32'hBEEF0000, 32'hBEEF0000, 32'hDEADBEEF, 32'h80000000};
    logic [31:0] r  [4] = '{32'h0000BEEF, 32'hFFFFBEEF, 32'hDEADBEEF, 32'h00000080};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, w[i], f3[i], lo[i]);
      vecs++; if (bus.O_WR_EN !== 1'b1 || bus.O_DST_ADDR !== 5'd9 || bus.O_DST_DATA !== r[i])
        begin miss++; $display("FAIL ext[%0d] got %0b x%0d=%h want 1 x9=%h", i, bus.O_WR_EN, bus.O_DST_ADDR, bus.O_DST_DATA, r[i]); end
    end
  endtask

  task automatic test_errors();
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h11223344, 3'd2, 2'd1);
    vecs++; if (bus.O_LD_ERR !== 1'b1 || bus.O_WR_EN !== 1'b0) begin miss++; $display("FAIL err_lw_mis got err%0b wr%0b want 1/0", bus.O_LD_ERR, bus.O_WR_EN); end
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h11223344, 3'd3, 2'd0);
    vecs++; if (bus.O_LD_ERR !== 1'b1 || bus.O_WR_EN !== 1'b0) begin miss++; $display("FAIL err_f3 got err%0b wr%0b want 1/0", bus.O_LD_ERR, bus.O_WR_EN); end
    cyc(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    vecs++; if (bus.O_WR_EN !== 1'b0 || bus.O_BUF_CNT !== 2'd0 || bus.O_LD_ERR !== 1'b0) begin miss++; $display("FAIL alu_x0 got wr%0b cnt%0d err%0b want 0/0/0", bus.O_WR_EN, bus.O_BUF_CNT, bus.O_LD_ERR); end
    cyc(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h0, 3'd1, 2'd1);
    vecs++; if (bus.O_LD_ERR !== 1'b1 || bus.O_WR_EN !== 1'b1 || bus.O_DST_ADDR !== 5'd4) begin miss++; $display("FAIL err_bypass got err%0b wr%0b x%0d want 1/1/x4", bus.O_LD_ERR, bus.O_WR_EN, bus.O_DST_ADDR); end
    cyc(1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'h12, 3'd2, 2'd0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99, 3'd2, 2'd0);
    vecs++; if (bus.O_WR_EN !== 1'b1 || bus.O_DST_ADDR !== 5'd6 || bus.O_DST_DATA !== 32'h66 || bus.O_BUF_CNT !== 2'd0)
      begin miss++; $display("FAIL ld_x0_drain got %0b x%0d=%h cnt%0d want 1 x6=66 cnt0", bus.O_WR_EN, bus.O_DST_ADDR, bus.O_DST_DATA, bus.O_BUF_CNT); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 5'd20, 32'h20, 1'b1, 5'd13, 32'h1, 3'd2, 2'd0);
    cyc(1'b1, 5'd21, 32'h21, 1'b1, 5'd14, 32'h2, 3'd2, 2'd0);
    vecs++; if (bus.O_BUF_CNT !== 2'd2) begin miss++; $display("FAIL rstmid_fill got %0d want 2", bus.O_BUF_CNT); end
    reset_pulse();
    vecs++; if (bus.O_WR_EN !== 1'b0 || bus.O_BUF_CNT !== 2'd0 || bus.O_ALU_READY !== 1'b1)
      begin miss++; $display("FAIL rstmid_clear got wr%0b cnt%0d rdy%0b want 0/0/1", bus.O_WR_EN, bus.O_BUF_CNT, bus.O_ALU_READY); end
    for (int i = 0; i < 3; i++) begin
      idle();
      vecs++; if (bus.O_WR_EN !== 1'b0) begin miss++; $display("FAIL rstmid_lost[%0d] got wr%0b x%0d want 0", i, bus.O_WR_EN, bus.O_DST_ADDR); end
    end
  endtask

  task automatic test_random();
    logic [2:0] f3;
    for (int i = 0; i < 600; i++) begin
      vecs++; if (bus.O_ALU_READY !== (q.size() < DEPTH)) begin miss++; $display("FAIL rnd_ready[%0d] got %0b want %0b", i, bus.O_ALU_READY, q.size() < DEPTH); end
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      cyc(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom,
          f3, ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3)));
      vecs++; if (bus.O_WR_EN !== exp_wr || bus.O_LD_ERR !== exp_err || bus.O_BUF_CNT !== 2'(exp_cnt))
        begin miss++; $display("FAIL rnd_ctrl[%0d] got wr%0b err%0b cnt%0d want wr%0b err%0b cnt%0d", i, bus.O_WR_EN, bus.O_LD_ERR, bus.O_BUF_CNT, exp_wr, exp_err, exp_cnt); end
      if (exp_wr) begin
        vecs++; if (bus.O_DST_ADDR !== exp_addr || bus.O_DST_DATA !== exp_data)
          begin miss++; $display("FAIL rnd_write[%0d] got x%0d=%h want x%0d=%h", i, bus.O_DST_ADDR, bus.O_DST_DATA, exp_addr, exp_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_backpressure();
    test_extension();
    test_errors();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
